// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
//
// Shared types and constants for the LC-3b cache controller.
//
// Contents:
//   cache_state_t  - controller states (IDLE, WRITEBACK, FILL)
//   PMEM_SEL_W1    - pmem address mux select: way 1 writeback address
//   PMEM_SEL_W2    - pmem address mux select: way 2 writeback address
//   PMEM_SEL_CPU   - pmem address mux select: CPU request address
//   victim_dirty() - dirty status of the way chosen for eviction
// ---------------------------------------------------------------------------
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITEBACK = 2'b01,
        FILL      = 2'b10
    } cache_state_t;

    // Writeback selects are {0, way index} so that the victim way taken
    // from lru_out can be concatenated straight onto a leading zero.
    localparam logic [1:0] PMEM_SEL_W1  = 2'b00;
    localparam logic [1:0] PMEM_SEL_W2  = 2'b01;
    localparam logic [1:0] PMEM_SEL_CPU = 2'b10;

    // lru_out names the victim way: 0 = way 1, 1 = way 2.
    function automatic logic victim_dirty(
        input logic lru_out,
        input logic isdirty_w1,
        input logic isdirty_w2
    );
        return lru_out ? isdirty_w2 : isdirty_w1;
    endfunction

endpackage

// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
//
// Control FSM for a two-way set-associative write-back cache. The datapath
// holds the tag/valid/dirty/data/LRU arrays; this block only decides which
// array strobes fire, which pmem transaction runs, and when the CPU request
// completes. Array contents are never cleared here.
//
// Ports:
//   clk                    in   sole clock, rising edge
//   reset_n                in   synchronous active-low reset
//   mem_read, mem_write    in   CPU request, held until mem_resp
//   mem_resp               out  CPU request complete (one-cycle pulse)
//   pmem_read, pmem_write  out  physical memory line request
//   pmem_resp              in   physical memory line transfer complete
//   ishit_w1, ishit_w2     in   per-way hit status
//   isdirty_w1, isdirty_w2 in   per-way dirty status
//   lru_out                in   victim way: 0 = way 1, 1 = way 2
//   load_*_w1/_w2          out  datapath array write strobes
//   dirty_array_w*_in      out  dirty bit value to write
//   load_lru, lru_in       out  LRU write strobe and value
//   datastore_in_mux_sel   out  0 = fill from pmem, 1 = CPU write merge
//   pmem_address_mux_sel   out  00 = w1 writeback, 01 = w2 writeback, 10 = CPU
//   hit_count, miss_count  out  16-bit wrapping performance counters
// ---------------------------------------------------------------------------
module cache_control
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,

    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,

    input  logic        ishit_w1,
    input  logic        ishit_w2,
    input  logic        isdirty_w1,
    input  logic        isdirty_w2,
    input  logic        lru_out,

    output logic        load_dirty_w1,
    output logic        load_valid_w1,
    output logic        load_tag_w1,
    output logic        load_datastore_w1,
    output logic        load_dirty_w2,
    output logic        load_valid_w2,
    output logic        load_tag_w2,
    output logic        load_datastore_w2,

    output logic        dirty_array_w1_in,
    output logic        dirty_array_w2_in,

    output logic        load_lru,
    output logic        lru_in,

    output logic        datastore_in_mux_sel,
    output logic [1:0]  pmem_address_mux_sel,

    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    cache_state_t state;
    cache_state_t next_state;

    logic request;
    logic any_hit;

    assign request = mem_read | mem_write;
    assign any_hit = ishit_w1 | ishit_w2;

    // State register and performance counters. Counters only move in IDLE
    // while a request is present: a hit completes that cycle, a miss leaves
    // for WRITEBACK or FILL. The 16-bit adds wrap naturally at 0xFFFF.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            state <= next_state;
            if (state == IDLE && request) begin
                if (any_hit) begin
                    hit_count <= hit_count + 16'd1;
                end else begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end

    // Next-state logic. Once a pmem transaction starts it runs to pmem_resp
    // even if the CPU drops its request in the meantime.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (request && !any_hit) begin
                    if (victim_dirty(lru_out, isdirty_w1, isdirty_w2)) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. Every strobe is low unless a state explicitly raises
    // it, and the pmem address points at the CPU address by default.
    always_comb begin
        mem_resp             = 1'b0;
        pmem_read            = 1'b0;
        pmem_write           = 1'b0;
        load_dirty_w1        = 1'b0;
        load_valid_w1        = 1'b0;
        load_tag_w1          = 1'b0;
        load_datastore_w1    = 1'b0;
        load_dirty_w2        = 1'b0;
        load_valid_w2        = 1'b0;
        load_tag_w2          = 1'b0;
        load_datastore_w2    = 1'b0;
        dirty_array_w1_in    = 1'b0;
        dirty_array_w2_in    = 1'b0;
        load_lru             = 1'b0;
        lru_in               = 1'b0;
        datastore_in_mux_sel = 1'b0;
        pmem_address_mux_sel = PMEM_SEL_CPU;

        unique case (state)
            IDLE: begin
                if (request && any_hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    // Way 2 takes priority when both report a hit, the same
                    // way the datapath read mux resolves it. The LRU then
                    // points at the way that was not just used.
                    lru_in   = ~ishit_w2;
                    if (mem_write) begin
                        datastore_in_mux_sel = 1'b1;
                        if (ishit_w2) begin
                            load_datastore_w2 = 1'b1;
                            load_dirty_w2     = 1'b1;
                            dirty_array_w2_in = 1'b1;
                        end else begin
                            load_datastore_w1 = 1'b1;
                            load_dirty_w1     = 1'b1;
                            dirty_array_w1_in = 1'b1;
                        end
                    end
                end
            end
            WRITEBACK: begin
                pmem_write           = 1'b1;
                pmem_address_mux_sel = {1'b0, lru_out};
            end
            FILL: begin
                pmem_read = 1'b1;
                // A freshly filled line is clean, so the dirty strobe fires
                // with the default dirty value of 0.
                if (pmem_resp) begin
                    if (lru_out) begin
                        load_datastore_w2 = 1'b1;
                        load_tag_w2       = 1'b1;
                        load_valid_w2     = 1'b1;
                        load_dirty_w2     = 1'b1;
                    end else begin
                        load_datastore_w1 = 1'b1;
                        load_tag_w1       = 1'b1;
                        load_valid_w1     = 1'b1;
                        load_dirty_w1     = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// ---------------------------------------------------------------------------
// tb_cache_control
//
// Self-checking bench for cache_control. A transaction-level model tracks
// whether the cache is ready, evicting a dirty line or refilling a line,
// plus the hit and miss totals, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cache_control;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp = 1'b0;
    logic        ishit_w1 = 1'b0;
    logic        ishit_w2 = 1'b0;
    logic        isdirty_w1 = 1'b0;
    logic        isdirty_w2 = 1'b0;
    logic        lru_out = 1'b0;
    logic        load_dirty_w1;
    logic        load_valid_w1;
    logic        load_tag_w1;
    logic        load_datastore_w1;
    logic        load_dirty_w2;
    logic        load_valid_w2;
    logic        load_tag_w2;
    logic        load_datastore_w2;
    logic        dirty_array_w1_in;
    logic        dirty_array_w2_in;
    logic        load_lru;
    logic        lru_in;
    logic        datastore_in_mux_sel;
    logic [1:0]  pmem_address_mux_sel;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       mem_resp;
        logic       pmem_read;
        logic       pmem_write;
        logic       load_dirty_w1;
        logic       load_valid_w1;
        logic       load_tag_w1;
        logic       load_datastore_w1;
        logic       load_dirty_w2;
        logic       load_valid_w2;
        logic       load_tag_w2;
        logic       load_datastore_w2;
        logic       dirty_w1_in;
        logic       dirty_w2_in;
        logic       load_lru;
        logic       lru_in;
        logic       ds_sel;
        logic [1:0] addr_sel;
    } outs_t;

    // Behavioural model: what the cache is busy with, and running totals.
    typedef enum {PH_READY, PH_EVICT, PH_REFILL} phase_t;
    phase_t model_phase = PH_READY;
    int     model_hits = 0;
    int     model_misses = 0;

    cache_control dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_resp             (mem_resp),
        .pmem_read            (pmem_read),
        .pmem_write           (pmem_write),
        .pmem_resp            (pmem_resp),
        .ishit_w1             (ishit_w1),
        .ishit_w2             (ishit_w2),
        .isdirty_w1           (isdirty_w1),
        .isdirty_w2           (isdirty_w2),
        .lru_out              (lru_out),
        .load_dirty_w1        (load_dirty_w1),
        .load_valid_w1        (load_valid_w1),
        .load_tag_w1          (load_tag_w1),
        .load_datastore_w1    (load_datastore_w1),
        .load_dirty_w2        (load_dirty_w2),
        .load_valid_w2        (load_valid_w2),
        .load_tag_w2          (load_tag_w2),
        .load_datastore_w2    (load_datastore_w2),
        .dirty_array_w1_in    (dirty_array_w1_in),
        .dirty_array_w2_in    (dirty_array_w2_in),
        .load_lru             (load_lru),
        .lru_in               (lru_in),
        .datastore_in_mux_sel (datastore_in_mux_sel),
        .pmem_address_mux_sel (pmem_address_mux_sel),
        .hit_count            (hit_count),
        .miss_count           (miss_count)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current inputs given what the cache is doing.
    function automatic outs_t expectOutputs();
        outs_t e;
        int    used_way;
        int    victim_way;
        e = '0;
        e.addr_sel = 2'b10;
        victim_way = lru_out ? 2 : 1;
        case (model_phase)
            PH_READY: begin
                if ((mem_read || mem_write) && (ishit_w1 || ishit_w2)) begin
                    used_way   = ishit_w2 ? 2 : 1;
                    e.mem_resp = 1'b1;
                    e.load_lru = 1'b1;
                    e.lru_in   = (used_way == 1);
                    if (mem_write) begin
                        e.ds_sel = 1'b1;
                        if (used_way == 2) begin
                            e.load_datastore_w2 = 1'b1;
                            e.load_dirty_w2     = 1'b1;
                            e.dirty_w2_in       = 1'b1;
                        end else begin
                            e.load_datastore_w1 = 1'b1;
                            e.load_dirty_w1     = 1'b1;
                            e.dirty_w1_in       = 1'b1;
                        end
                    end
                end
            end
            PH_EVICT: begin
                e.pmem_write = 1'b1;
                e.addr_sel   = (victim_way == 2) ? 2'b01 : 2'b00;
            end
            PH_REFILL: begin
                e.pmem_read = 1'b1;
                if (pmem_resp) begin
                    if (victim_way == 2) begin
                        e.load_datastore_w2 = 1'b1;
                        e.load_tag_w2       = 1'b1;
                        e.load_valid_w2     = 1'b1;
                        e.load_dirty_w2     = 1'b1;
                    end else begin
                        e.load_datastore_w1 = 1'b1;
                        e.load_tag_w1       = 1'b1;
                        e.load_valid_w1     = 1'b1;
                        e.load_dirty_w1     = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    // Advance the model across the coming rising edge.
    task automatic advanceModel();
        bit victim_is_dirty;
        victim_is_dirty = lru_out ? isdirty_w2 : isdirty_w1;
        if (!reset_n) begin
            model_phase  = PH_READY;
            model_hits   = 0;
            model_misses = 0;
        end else begin
            case (model_phase)
                PH_READY: begin
                    if (mem_read || mem_write) begin
                        if (ishit_w1 || ishit_w2) begin
                            model_hits = (model_hits + 1) % 65536;
                        end else begin
                            model_misses = (model_misses + 1) % 65536;
                            model_phase  = victim_is_dirty ? PH_EVICT : PH_REFILL;
                        end
                    end
                end
                PH_EVICT:  if (pmem_resp) model_phase = PH_REFILL;
                PH_REFILL: if (pmem_resp) model_phase = PH_READY;
                default:   model_phase = PH_READY;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag);
        outs_t obs;
        outs_t exp;
        obs = {mem_resp, pmem_read, pmem_write,
               load_dirty_w1, load_valid_w1, load_tag_w1, load_datastore_w1,
               load_dirty_w2, load_valid_w2, load_tag_w2, load_datastore_w2,
               dirty_array_w1_in, dirty_array_w2_in, load_lru, lru_in,
               datastore_in_mux_sel, pmem_address_mux_sel};
        exp = expectOutputs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s outputs: observed %b expected %b", tag, obs, exp);
        end
        checks++;
        assert (hit_count === 16'(model_hits)) else begin
            errors++;
            $error("[TB] FAIL %s hit_count: observed %h expected %h", tag, hit_count, 16'(model_hits));
        end
        checks++;
        assert (miss_count === 16'(model_misses)) else begin
            errors++;
            $error("[TB] FAIL %s miss_count: observed %h expected %h", tag, miss_count, 16'(model_misses));
        end
    endtask

    task automatic expectBits(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check mid-cycle, then
    // let the model follow the design across the next rising edge.
    task automatic applyStimulus(
        input logic  rd, input logic wr,
        input logic  h1, input logic h2,
        input logic  d1, input logic d2,
        input logic  lru, input logic presp,
        input logic  rstn, input string tag
    );
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        ishit_w1   = h1;
        ishit_w2   = h2;
        isdirty_w1 = d1;
        isdirty_w2 = d2;
        lru_out    = lru;
        pmem_resp  = presp;
        reset_n    = rstn;
        #1;
        checkOutput(tag);
        advanceModel();
    endtask

    initial begin
        int r;
        $display("[TB] cache_control bench starting");

        // Reset and quiet idle.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_idle");
        expectBits("reset_addr_sel", 16'(pmem_address_mux_sel), 16'h0002);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle_no_req");

        // Read hit on way 1, then write hit on way 2, then both ways hit.
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, "read_hit_w1");
        expectBits("read_hit_w1_resp", 16'(mem_resp), 16'h0001);
        expectBits("read_hit_w1_lru_in", 16'(lru_in), 16'h0001);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 1, "write_hit_w2");
        expectBits("read_hit_count", hit_count, 16'h0001);
        expectBits("write_hit_w2_ds", 16'(load_datastore_w2), 16'h0001);
        applyStimulus(1, 0, 1, 1, 0, 0, 0, 0, 1, "both_hit_read");
        applyStimulus(0, 1, 1, 1, 0, 0, 1, 0, 1, "both_hit_write");
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 1, "write_hit_w1");

        // Clean miss to way 2, pmem answers on the fifth FILL cycle.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, "clean_miss");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, "clean_fill_wait");
        end
        expectBits("clean_fill_pmem_read", 16'(pmem_read), 16'h0001);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 1, "clean_fill_resp");
        expectBits("clean_fill_tag_w2", 16'(load_tag_w2), 16'h0001);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 1, "clean_retry_hit");
        expectBits("clean_miss_count", miss_count, 16'h0001);

        // Dirty miss on way 1: writeback then fill, then the retried write hits.
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, "dirty_miss");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, "writeback_wait");
        end
        expectBits("writeback_addr_sel", 16'(pmem_address_mux_sel), 16'h0000);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 1, 1, "writeback_resp");
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, "dirty_fill_wait");
        expectBits("dirty_fill_pmem_read", 16'(pmem_read), 16'h0001);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 1, 1, "dirty_fill_resp");
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 1, "dirty_retry_hit");

        // Request dropped mid-fill does not abort the transfer.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, "abort_miss");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "abort_dropped");
        expectBits("abort_still_reading", 16'(pmem_read), 16'h0001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, "abort_fill_resp");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "abort_back_idle");

        // Reset while in FILL.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, "rst_mid_miss");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, "rst_mid_fill");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, "rst_after");
        expectBits("rst_pmem_read", 16'(pmem_read), 16'h0000);
        expectBits("rst_miss_count", miss_count, 16'h0000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 3));
            applyStimulus(r == 1 || r == 3, r == 2,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                          $urandom_range(0, 39) != 0, "random");
        end

        // Hit counter wrap.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "wrap_reset");
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, "wrap_hits");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "wrap_pause");
        expectBits("wrap_preload", hit_count, 16'hFFFF);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 1, "wrap_hit");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "wrap_after");
        expectBits("wrap_zero", hit_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
